// File: rtl/residual_layernorm_if.sv
// Vector handshake bundle for the residual-add + layer-norm stage.
// valid_in is sampled only on an edge where in_ready=1; valid_out is a one-cycle pulse when y_out updates.
interface residual_layernorm_if #(
  parameter int EMBED_DIM  = 8,
  parameter int DATA_WIDTH = 16
);
  logic                            valid_in;
  logic                            in_ready;
  logic [EMBED_DIM*DATA_WIDTH-1:0] res_in;
  logic [EMBED_DIM*DATA_WIDTH-1:0] attn_in;
  logic [EMBED_DIM*DATA_WIDTH-1:0] gamma_flat;
  logic [EMBED_DIM*DATA_WIDTH-1:0] beta_flat;
  logic [EMBED_DIM*DATA_WIDTH-1:0] y_out;
  logic                            valid_out;
  logic [3:0]                      dbg_state;

  modport master (
    output valid_in, res_in, attn_in, gamma_flat, beta_flat,
    input  in_ready, y_out, valid_out, dbg_state
  );

  modport slave (
    input  valid_in, res_in, attn_in, gamma_flat, beta_flat,
    output in_ready, y_out, valid_out, dbg_state
  );
endinterface

// File: rtl/residual_layernorm.sv
// Saturating residual add followed by Q8.8 layer normalisation, one element per cycle,
// with bit-serial square root and reciprocal.
module residual_layernorm #(
  parameter int EMBED_DIM  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int EPS        = 1
) (
  input logic                clk,
  input logic                rst,
  residual_layernorm_if.slave bus
);
  localparam int N  = EMBED_DIM;
  localparam int DW = DATA_WIDTH;
  localparam int L  = $clog2(EMBED_DIM);
  localparam int SW = DW + L;
  localparam int CW = (L + 1 > 5) ? L + 1 : 5;
  localparam logic signed [39:0] SAT_MAX = (40'sd1 <<< (DW - 1)) - 40'sd1;
  localparam logic signed [39:0] SAT_MIN = -(40'sd1 <<< (DW - 1));

  typedef enum logic [3:0] {
    S_IDLE, S_ADD, S_MEAN, S_VAR, S_VFIN, S_SQRT, S_RECIP, S_NORM, S_DONE
  } state_t;

  function automatic logic signed [DW-1:0] sat(input logic signed [39:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DW-1:0];
    else                  return v[DW-1:0];
  endfunction

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_in_ready;
  logic                  r_valid_out;
  logic [N*DW-1:0]       r_y;
  logic signed [SW-1:0]  r_sum;
  logic signed [DW-1:0]  r_mean;
  logic [39:0]           r_sq;
  logic [31:0]           r_rad;
  logic [17:0]           r_srem;
  logic [15:0]           r_root;
  logic [16:0]           r_dvd;
  logic [16:0]           r_drem;
  logic [16:0]           r_inv;
  logic signed [DW-1:0]  r_s     [N];
  logic signed [DW-1:0]  r_attn  [N];
  logic signed [DW-1:0]  r_gamma [N];
  logic signed [DW-1:0]  r_beta  [N];
  logic signed [DW-1:0]  r_stage [N];
  logic signed [DW:0]    r_d     [N];

  logic [L-1:0]          w_idx;
  logic                  w_last;
  logic signed [39:0]    w_add;
  logic signed [DW-1:0]  w_s;
  logic signed [DW:0]    w_d;
  logic signed [39:0]    w_dsq;
  logic [39:0]           w_var_full;
  logic [31:0]           w_var;
  logic [19:0]           w_srem_sh;
  logic [19:0]           w_trial;
  logic                  w_sqrt_ge;
  logic [17:0]           w_drem_sh;
  logic                  w_div_ge;
  logic signed [39:0]    w_dn;
  logic signed [DW-1:0]  w_n;
  logic signed [39:0]    w_ng;
  logic signed [39:0]    w_ypre;
  logic signed [DW-1:0]  w_y;
  logic [N*DW-1:0]       w_stage_flat;

  assign w_idx  = r_cnt[L-1:0];
  assign w_last = (r_cnt == CW'(N - 1));

  assign w_add = 40'(r_s[w_idx]) + 40'(r_attn[w_idx]);
  assign w_s   = sat(w_add);
  assign w_d   = 17'(r_s[w_idx]) - 17'(r_mean);
  assign w_dsq = 40'(w_d) * 40'(w_d);

  assign w_var_full = (r_sq >> L) + 40'(EPS);
  assign w_var      = (|w_var_full[39:32]) ? 32'hFFFF_FFFF : w_var_full[31:0];

  // Digit-by-digit root: bring down two radicand bits, try (4*root + 1).
  assign w_srem_sh = {r_srem, r_rad[31:30]};
  assign w_trial   = {2'b00, r_root, 2'b01};
  assign w_sqrt_ge = (w_srem_sh >= w_trial);

  assign w_drem_sh = {r_drem, r_dvd[16]};
  assign w_div_ge  = (w_drem_sh >= {2'b00, r_root});

  assign w_dn   = 40'(r_d[w_idx]) * 40'($signed({1'b0, r_inv}));
  assign w_n    = sat(w_dn >>> 8);
  assign w_ng   = 40'(w_n) * 40'(r_gamma[w_idx]);
  assign w_ypre = (w_ng >>> 8) + 40'(r_beta[w_idx]);
  assign w_y    = sat(w_ypre);

  always_comb begin
    w_stage_flat = '0;
    for (int i = 0; i < N; i++) w_stage_flat[i*DW +: DW] = r_stage[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_valid_out <= 1'b0;
      r_y         <= '0;
      r_sum       <= '0;
      r_mean      <= '0;
      r_sq        <= '0;
      r_rad       <= '0;
      r_srem      <= '0;
      r_root      <= '0;
      r_dvd       <= '0;
      r_drem      <= '0;
      r_inv       <= '0;
    end else begin
      r_valid_out <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.valid_in) begin
          r_state    <= S_ADD;
          r_cnt      <= '0;
          r_sum      <= '0;
          r_sq       <= '0;
          r_in_ready <= 1'b0;
        end
        S_ADD: begin
          r_sum <= r_sum + SW'(w_s);
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_state <= S_MEAN;
        end
        S_MEAN: begin
          r_mean  <= DW'(r_sum >>> L);
          r_state <= S_VAR;
        end
        S_VAR: begin
          r_sq  <= r_sq + $unsigned(w_dsq);
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_state <= S_VFIN;
        end
        S_VFIN: begin
          r_rad   <= w_var;
          r_srem  <= '0;
          r_root  <= '0;
          r_dvd   <= 17'h1_0000;
          r_drem  <= '0;
          r_inv   <= '0;
          r_cnt   <= '0;
          r_state <= S_SQRT;
        end
        S_SQRT: begin
          r_srem <= w_sqrt_ge ? 18'(w_srem_sh - w_trial) : 18'(w_srem_sh);
          r_root <= {r_root[14:0], w_sqrt_ge};
          r_rad  <= r_rad << 2;
          r_cnt  <= (r_cnt == CW'(15)) ? '0 : r_cnt + 1'b1;
          if (r_cnt == CW'(15)) r_state <= S_RECIP;
        end
        S_RECIP: begin
          r_drem <= w_div_ge ? 17'(w_drem_sh - {2'b00, r_root}) : 17'(w_drem_sh);
          r_dvd  <= r_dvd << 1;
          r_inv  <= {r_inv[15:0], w_div_ge};
          r_cnt  <= (r_cnt == CW'(16)) ? '0 : r_cnt + 1'b1;
          if (r_cnt == CW'(16)) r_state <= S_NORM;
        end
        S_NORM: begin
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_y         <= w_stage_flat;
          r_valid_out <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Element storage carries no reset: every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_IDLE && bus.valid_in) begin
      for (int i = 0; i < N; i++) begin
        r_s[i]     <= bus.res_in[i*DW +: DW];
        r_attn[i]  <= bus.attn_in[i*DW +: DW];
        r_gamma[i] <= bus.gamma_flat[i*DW +: DW];
        r_beta[i]  <= bus.beta_flat[i*DW +: DW];
      end
    end
    if (r_state == S_ADD)  r_s[w_idx]     <= w_s;
    if (r_state == S_VAR)  r_d[w_idx]     <= w_d;
    if (r_state == S_NORM) r_stage[w_idx] <= w_y;
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.valid_out = r_valid_out;
  assign bus.y_out     = r_y;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_residual_layernorm.sv
// Directed bench for residual_layernorm: hand-computed vectors, latency, busy and reset behaviour.
module tb_residual_layernorm;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int W  = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  residual_layernorm_if #(.EMBED_DIM(N), .DATA_WIDTH(DW)) bus ();
  residual_layernorm #(.EMBED_DIM(N), .DATA_WIDTH(DW), .EPS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         prev_vo = 1'b0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      check_val("vo_pulse", W'(prev_vo), '0);
      if (exp_q.size() == 0) check_val("unexp_vo", W'(1), '0);
      else begin
        check_val("y_out", bus.y_out, exp_q.pop_front());
        check_val("latency", W'(cyc - acc_q.pop_front()), W'(60));
      end
    end
    prev_vo = bus.valid_out;
  end

  // vector builders
  function automatic logic [W-1:0] alt(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = (i % 2 == 0) ? a : b;
    return v;
  endfunction

  function automatic logic [W-1:0] halves(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = (i < N / 2) ? a : b;
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic [W-1:0] r, input logic [W-1:0] a,
                       input logic [W-1:0] g, input logic [W-1:0] b);
    bus.res_in     = r;
    bus.attn_in    = a;
    bus.gamma_flat = g;
    bus.beta_flat  = b;
    bus.valid_in   = 1'b1;
  endtask

  task automatic wait_accept(output int acc);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check_val("accept_timeout", W'(k), '0);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic send(input logic [W-1:0] r, input logic [W-1:0] a,
                      input logic [W-1:0] g, input logic [W-1:0] b, input logic [W-1:0] e);
    int acc;
    drive(r, a, g, b);
    wait_accept(acc);
    bus.valid_in = 1'b0;
    check_val("busy_ready", W'(bus.in_ready), '0);
    exp_q.push_back(e);
    acc_q.push_back(acc);
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check_val("done_timeout", W'(exp_q.size()), '0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  logic [W-1:0] z, one, alt_v, alt_y, ss_y;

  initial begin
    int a0, a1, acc;
    z     = '0;
    one   = alt(16'h0100, 16'h0100);
    alt_v = alt(16'h0100, 16'hFF00);
    alt_y = alt(16'h0100, 16'hFF00);
    ss_y  = alt(16'h0280, 16'hFE80);
    bus.valid_in = 1'b0;
    bus.res_in = '0; bus.attn_in = '0; bus.gamma_flat = '0; bus.beta_flat = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_y", bus.y_out, '0);
    check_val("rst_vo", W'(bus.valid_out), '0);
    check_val("rst_ready", W'(bus.in_ready), W'(1));
    check_val("rst_state", W'(bus.dbg_state), '0);
    rst = 1'b0;

    send(z, alt_v, one, z, alt_y);
    wait_done();
    send(z, alt_v, alt(16'h0200, 16'h0200), alt(16'h0080, 16'h0080), ss_y);
    wait_done();
    send(alt(16'h0200, 16'h0200), alt(16'h0100, 16'h0100), one, alt(16'h0080, 16'h0080),
         alt(16'h0080, 16'h0080));
    wait_done();
    send(halves(16'h7F00, 16'h8100), halves(16'h7F00, 16'h8100), one, z,
         halves(16'h0100, 16'hFF00));
    wait_done();

    // back-to-back: second vector held on the bus during the first computation
    drive(z, alt_v, one, z);
    wait_accept(a0);
    exp_q.push_back(alt_y);
    acc_q.push_back(a0);
    drive(z, alt_v, alt(16'h0200, 16'h0200), alt(16'h0080, 16'h0080));
    wait_accept(a1);
    bus.valid_in = 1'b0;
    exp_q.push_back(ss_y);
    acc_q.push_back(a1);
    check_val("b2b_spacing", W'(a1 - a0), W'(61));
    wait_done();

    // reset in cycle 30 of a run, with a new vector already offered during reset
    drive(z, alt_v, one, z);
    wait_accept(acc);
    bus.valid_in = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(alt(16'h0200, 16'h0200), alt(16'h0100, 16'h0100), one, alt(16'h0080, 16'h0080));
    @(posedge clk);
    #1;
    check_val("abort_y", bus.y_out, '0);
    check_val("abort_vo", W'(bus.valid_out), '0);
    check_val("abort_ready", W'(bus.in_ready), W'(1));
    check_val("abort_state", W'(bus.dbg_state), '0);
    @(negedge clk);
    rst = 1'b0;
    wait_accept(acc);
    bus.valid_in = 1'b0;
    exp_q.push_back(alt(16'h0080, 16'h0080));
    acc_q.push_back(acc);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
